// File: rtl/onehot_enc_pkg.sv
// Shared types and helpers for the sequential one-hot encoder.
// Optional strict mode is selected with the ONEHOT_STRICT_EN macro.
package onehot_enc_pkg;

    localparam int CODE_W_DEF = 3;
    localparam logic [CODE_W_DEF-1:0] CODE_ZERO = '0;

    typedef logic [0:0] enc_state_t;

    localparam enc_state_t IDLE = 1'b0;
    localparam enc_state_t EMIT = 1'b1;

    // Bit index i maps to code i+1; code 0 is reserved for the empty vector.
    function automatic int unsigned code_of(input int unsigned idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/onehot_encoder_seq_lsb.sv
// Lowest-set-bit finder: index, isolated mask, non-empty and multi-hot flags.
// The multi-hot flag feeds the ONEHOT_STRICT_EN build of the top.
module lowest_set_bit
    import onehot_enc_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int VEC_W  = 2**CODE_W
) (
    input  logic [VEC_W-2:0]  vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              any_o,
    output logic [VEC_W-2:0]  onehot_mask_o,
    output logic              multi_o
);

    localparam int DW = VEC_W - 1;

    assign any_o         = |vec_i;
    assign onehot_mask_o = vec_i & (~vec_i + DW'(1));
    // Clearing the lowest bit leaves something only if two or more were set.
    assign multi_o       = |(vec_i & (vec_i - DW'(1)));

    always_comb begin
        idx_o = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = CODE_W'(i);
        end
    end

endmodule

// File: rtl/onehot_encoder_seq.sv
// Sequential vector-to-code encoder, one registered code beat per cycle.
// ONEHOT_STRICT_EN: multi-hot vectors collapse to a single error beat.
module onehot_encoder_seq
    import onehot_enc_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int VEC_W  = 2**CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              out_err
);

    localparam int DW = VEC_W - 1;

    enc_state_t        state_q, state_d;
    logic [DW-1:0]     pend_q, pend_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              last_q, last_d;
    logic              oerr_q, oerr_d;

    logic [DW-1:0]     lsb_in;
    logic [DW-1:0]     lsb_mask;
    logic [CODE_W-1:0] lsb_idx;
    logic              lsb_any;
    logic              lsb_multi;

    logic [DW-1:0]     rem;
    logic [CODE_W-1:0] beat_code;
    logic              beat_last;
    logic              beat_err;
    logic              src_err;
    logic              accept;
    logic              xfer;
    logic              load;

    // The same finder serves the incoming vector and the pending bits.
    assign lsb_in = (state_q == IDLE) ? in_vec[DW-1:0] : pend_q;

    lowest_set_bit #(
        .CODE_W (CODE_W),
        .VEC_W  (VEC_W)
    ) u_lsb (
        .vec_i         (lsb_in),
        .idx_o         (lsb_idx),
        .any_o         (lsb_any),
        .onehot_mask_o (lsb_mask),
        .multi_o       (lsb_multi)
    );

    assign in_ready  = !rst && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign xfer      = valid_q && out_ready;

    assign rem       = lsb_in & ~lsb_mask;
    assign beat_code = lsb_any ? CODE_W'(code_of(32'(lsb_idx)))
                               : CODE_W'(CODE_ZERO);
    assign beat_last = (rem == '0);
    assign src_err   = (state_q == IDLE) ? in_vec[DW] : err_q;
    assign beat_err  = beat_last && src_err;

`ifndef ONEHOT_STRICT_EN
    logic unused_multi;
    assign unused_multi = lsb_multi;
`endif

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = err_q;
        valid_d = valid_q;
        code_d  = code_q;
        last_d  = last_q;
        oerr_d  = oerr_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                    err_d   = in_vec[DW];
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pend_d = rem;
            code_d = beat_code;
            last_d = beat_last;
            oerr_d = beat_err;
        end

`ifdef ONEHOT_STRICT_EN
        if (accept && lsb_multi) begin
            pend_d = '0;
            err_d  = 1'b1;
            code_d = CODE_W'(CODE_ZERO);
            last_d = 1'b1;
            oerr_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            code_q  <= '0;
            last_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            last_q  <= last_d;
            oerr_q  <= oerr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign out_last  = last_q;
    assign out_err   = oerr_q;

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Bench for onehot_encoder_seq: vector table, hand sequences, random vs model.
// Expectations follow ONEHOT_STRICT_EN when the macro is defined.
module tb_onehot_encoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_last;
    logic       out_err;

    always #5 clk = ~clk;

    onehot_encoder_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_err   (out_err)
    );

`ifdef ONEHOT_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    typedef struct {
        logic [7:0] vec;
        int         hold;
        int         n;
        logic [8:0] codes;
        logic       err;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [4:0] exp_q[$];
    vec_t       tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: list of set bits in [6:0] ascending, code = position+1.
    function automatic void model(input logic [7:0] v);
        int cnt;
        int n;
        exp_q.delete();
        cnt = $countones(v[6:0]);
        n   = 0;
        if (STRICT && cnt > 1) begin
            exp_q.push_back({3'd0, 1'b1, 1'b1});
            return;
        end
        if (cnt == 0) begin
            exp_q.push_back({3'd0, 1'b1, v[7]});
            return;
        end
        for (int k = 0; k < 7; k++) begin
            if (v[k]) begin
                n++;
                exp_q.push_back({3'(k + 1), n == cnt, (n == cnt) && v[7]});
            end
        end
    endfunction

    task automatic run_vec(input logic [7:0] v, input int hold,
                           input int stall_pct);
        int guard;
        int h;
        h     = hold;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_vec   = 8'($urandom);
        chk("latency1_valid", out_valid, 1);
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_code_last_err", {out_code, out_last, out_err}, exp_q[0]);
            chk("busy_in_ready", in_ready, 0);
            if (h > 0) begin
                out_ready = 1'b0;
                h--;
            end else begin
                out_ready = ($urandom_range(99) >= stall_pct);
            end
            tick();
            if (out_ready) void'(exp_q.pop_front());
            guard++;
        end
        chk("beats_done", exp_q.size(), 0);
        out_ready = 1'b0;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;

        tbl.push_back('{8'h00, 0, 1, 9'd0, 1'b0});
        tbl.push_back('{8'h04, 0, 1, {6'd0, 3'd3}, 1'b0});
        if (STRICT) tbl.push_back('{8'h29, 0, 1, 9'd0, 1'b1});
        else        tbl.push_back('{8'h29, 0, 3, {3'd6, 3'd4, 3'd1}, 1'b0});
        tbl.push_back('{8'h81, 0, 1, {6'd0, 3'd1}, 1'b1});
        tbl.push_back('{8'h80, 0, 1, 9'd0, 1'b1});
        tbl.push_back('{8'h40, 0, 1, {6'd0, 3'd7}, 1'b0});
        if (STRICT) tbl.push_back('{8'h03, 3, 1, 9'd0, 1'b1});
        else        tbl.push_back('{8'h03, 3, 2, {3'd0, 3'd2, 3'd1}, 1'b0});

        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        foreach (tbl[t]) begin
            exp_q.delete();
            for (int j = 0; j < tbl[t].n; j++) begin
                logic [8:0] cw;
                cw = tbl[t].codes >> (3 * j);
                exp_q.push_back({cw[2:0], j == tbl[t].n - 1,
                                 (j == tbl[t].n - 1) && tbl[t].err});
            end
            run_vec(tbl[t].vec, tbl[t].hold, 0);
        end

        // Reset while the first beat of 8'h0F is being transferred.
        in_valid = 1'b1;
        in_vec   = 8'h0F;
        tick();
        in_valid = 1'b0;
        chk("abort_first_valid", out_valid, 1);
        chk("abort_first_code", out_code, 1);
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready_rst", in_ready, 0);
        rst = 1'b0;
        tick();
        chk("abort_stays_idle", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        out_ready = 1'b0;

        for (int r = 0; r < 150; r++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (r % 4 == 0) v = v & 8'h81;
            model(v);
            run_vec(v, 0, 30);
            if ($urandom_range(3) == 0) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
